// File: rtl/de_multiplexer_if.sv
// Bus bundle for de_multiplexer: routed data in, two registered destinations out.
// Counter signals exist only when DEMUX_ROUTE_CNT_EN is defined.
interface de_multiplexer_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] A;
    logic [1:0]       S;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic             B_vld;
    logic             C_vld;
`ifdef DEMUX_ROUTE_CNT_EN
    logic [CNT_W-1:0] B_cnt;
    logic [CNT_W-1:0] C_cnt;

    modport master (output A, S, input B, C, B_vld, C_vld, B_cnt, C_cnt);
    modport slave  (input A, S, output B, C, B_vld, C_vld, B_cnt, C_cnt);
`else
    modport master (output A, S, input B, C, B_vld, C_vld);
    modport slave  (input A, S, output B, C, B_vld, C_vld);
`endif
endinterface

// File: rtl/de_multiplexer.sv
// Registered 1-to-2 router: S selects B, C, both or neither; one-cycle latency.
// Optional saturating per-destination route counters under DEMUX_ROUTE_CNT_EN.
module de_multiplexer #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             rst,
    de_multiplexer_if.slave bus
);
    logic loadB;
    logic loadC;

    // Unknown selects fall into the default branch and behave as a drop.
    always_comb begin
        loadB = 1'b0;
        loadC = 1'b0;
        case (bus.S)
            2'b00:   loadB = 1'b1;
            2'b01:   loadC = 1'b1;
            2'b10: begin
                loadB = 1'b1;
                loadC = 1'b1;
            end
            default: begin
                loadB = 1'b0;
                loadC = 1'b0;
            end
        endcase
    end

    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] cReg;
    logic             bVld;
    logic             cVld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bReg <= '0;
            cReg <= '0;
            bVld <= 1'b0;
            cVld <= 1'b0;
        end else begin
            if (loadB) bReg <= bus.A;
            if (loadC) cReg <= bus.A;
            bVld <= loadB;
            cVld <= loadC;
        end
    end

    assign bus.B     = bReg;
    assign bus.C     = cReg;
    assign bus.B_vld = bVld;
    assign bus.C_vld = cVld;

`ifdef DEMUX_ROUTE_CNT_EN
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0] bCnt;
    logic [CNT_W-1:0] cCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bCnt <= '0;
            cCnt <= '0;
        end else begin
            if (loadB) bCnt <= satInc(bCnt);
            if (loadC) cCnt <= satInc(cCnt);
        end
    end

    assign bus.B_cnt = bCnt;
    assign bus.C_cnt = cCnt;
`endif
endmodule

// File: tb/tb_de_multiplexer.sv
// Directed bench for de_multiplexer: reset, routing modes, mid-stream reset,
// optional counter saturation, and a seeded random run against a reference model.
module tb_de_multiplexer;
    localparam int WIDTH = 2;
    localparam int CNT_W = 2;

    logic tb_clk = 1'b0;
    logic rst    = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 tb_clk = ~tb_clk;

    de_multiplexer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    de_multiplexer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step(input logic [WIDTH-1:0] a, input logic [1:0] s);
        bus.A = a;
        bus.S = s;
        @(posedge tb_clk);
        #1;
    endtask

    task automatic expectOut(input string name, input logic [WIDTH-1:0] eb, input logic [WIDTH-1:0] ec,
                             input logic ebv, input logic ecv);
        checks++;
        if (bus.B !== eb || bus.C !== ec || bus.B_vld !== ebv || bus.C_vld !== ecv) begin
            errors++;
            $display("FAIL %s: got B=%b C=%b Bv=%b Cv=%b, expected B=%b C=%b Bv=%b Cv=%b",
                     name, bus.B, bus.C, bus.B_vld, bus.C_vld, eb, ec, ebv, ecv);
        end
    endtask

    task automatic test_reset;
        bus.A = 2'b00;
        bus.S = 2'b11;
        #10 rst = 1'b1;
        #1;
        expectOut("reset_async", 2'b00, 2'b00, 1'b0, 1'b0);
        bus.A = 2'b11;
        bus.S = 2'b10;
        #25;
        expectOut("reset_ignores_inputs", 2'b00, 2'b00, 1'b0, 1'b0);
        bus.S = 2'b11;
        #4 rst = 1'b0;
        @(posedge tb_clk);
        #1;
        expectOut("after_reset_drop", 2'b00, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_routes;
        step(2'b10, 2'b00);
        expectOut("route_B", 2'b10, 2'b00, 1'b1, 1'b0);
        step(2'b01, 2'b01);
        expectOut("route_C", 2'b10, 2'b01, 1'b0, 1'b1);
        step(2'b11, 2'b10);
        expectOut("broadcast", 2'b11, 2'b11, 1'b1, 1'b1);
        step(2'b00, 2'b11);
        expectOut("drop_hold", 2'b11, 2'b11, 1'b0, 1'b0);
        step(2'b01, 2'b11);
        expectOut("drop_hold2", 2'b11, 2'b11, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        step(2'b01, 2'b00);
        expectOut("b2b_B", 2'b01, 2'b11, 1'b1, 1'b0);
        step(2'b10, 2'b00);
        expectOut("b2b_B_again", 2'b10, 2'b11, 1'b1, 1'b0);
        step(2'b00, 2'b01);
        expectOut("b2b_C", 2'b10, 2'b00, 1'b0, 1'b1);
        step(2'b11, 2'b01);
        expectOut("b2b_C_again", 2'b10, 2'b11, 1'b0, 1'b1);
    endtask

    task automatic test_mid_reset;
        step(2'b01, 2'b10);
        expectOut("pre_reset_load", 2'b01, 2'b01, 1'b1, 1'b1);
        bus.A = 2'b10;
        bus.S = 2'b10;
        #3 rst = 1'b1;
        #1;
        expectOut("mid_reset_async", 2'b00, 2'b00, 1'b0, 1'b0);
        @(posedge tb_clk);
        #1;
        expectOut("mid_reset_held", 2'b00, 2'b00, 1'b0, 1'b0);
        bus.S = 2'b11;
        #3 rst = 1'b0;
        @(posedge tb_clk);
        #1;
        expectOut("mid_reset_release", 2'b00, 2'b00, 1'b0, 1'b0);
    endtask

`ifdef DEMUX_ROUTE_CNT_EN
    task automatic test_counters;
        logic [CNT_W-1:0] expB [5];
        logic [CNT_W-1:0] expC [5];
        expB = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        expC = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            step(2'(i), 2'b10);
            checks++;
            if (bus.B_cnt !== expB[i] || bus.C_cnt !== expC[i]) begin
                errors++;
                $display("FAIL cnt_sat[%0d]: got B_cnt=%0d C_cnt=%0d, expected %0d/%0d",
                         i, bus.B_cnt, bus.C_cnt, expB[i], expC[i]);
            end
        end
        step(2'b00, 2'b11);
        checks++;
        if (bus.B_cnt !== 2'd3 || bus.C_cnt !== 2'd3) begin
            errors++;
            $display("FAIL cnt_drop_hold: got B_cnt=%0d C_cnt=%0d, expected 3/3", bus.B_cnt, bus.C_cnt);
        end
    endtask
`endif

    task automatic test_random;
        logic [WIDTH-1:0] mB, mC, a;
        logic             mBv, mCv;
        logic [1:0]       s;
        logic [CNT_W-1:0] mBc, mCc;
        // Start from a known state with a mid-cycle reset pulse.
        #4 rst = 1'b1;
        #3 rst = 1'b0;
        bus.S = 2'b11;
        mB = '0; mC = '0; mBv = 1'b0; mCv = 1'b0; mBc = '0; mCc = '0;
        for (int i = 0; i < 200; i++) begin
            a = WIDTH'($urandom);
            s = 2'($urandom);
            step(a, s);
            mBv = (s == 2'b00) || (s == 2'b10);
            mCv = (s == 2'b01) || (s == 2'b10);
            if (mBv) mB = a;
            if (mCv) mC = a;
            if (mBv && mBc != '1) mBc = mBc + 1'b1;
            if (mCv && mCc != '1) mCc = mCc + 1'b1;
            expectOut($sformatf("random[%0d]", i), mB, mC, mBv, mCv);
        end
`ifdef DEMUX_ROUTE_CNT_EN
        checks++;
        if (bus.B_cnt !== mBc || bus.C_cnt !== mCc) begin
            errors++;
            $display("FAIL random_cnt: got B_cnt=%0d C_cnt=%0d, expected %0d/%0d",
                     bus.B_cnt, bus.C_cnt, mBc, mCc);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_routes();
        test_back_to_back();
        test_mid_reset();
`ifdef DEMUX_ROUTE_CNT_EN
        test_counters();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
